// File: rtl/minmax_sequencer.sv
// Frame min/max sequencer that time-shares one external 4-bit comparator.
// The first element of a frame seeds max/min directly. Each later element
// takes one accept cycle plus CMP_MAX and CMP_MIN cycles on the comparator.
// Optional build macro MINMAX_INDEX_EN adds the max_idx/min_idx position outputs.
`default_nettype none

module minmax_sequencer #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic [3:0]       cmp_a,
   output logic [3:0]       cmp_b,
   input  logic [2:0]       cmp_r,
   output logic [3:0]       max_out,
   output logic [3:0]       min_out,
   output logic [CNT_W-1:0] count,
`ifdef MINMAX_INDEX_EN
   output logic [CNT_W-1:0] max_idx,
   output logic [CNT_W-1:0] min_idx,
`endif
   output logic             busy,
   output logic             done
);

   localparam int unsigned  DATA_W  = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [2:0]   R_GT    = 3'b100;
   localparam logic [2:0]   R_LT    = 3'b001;

   typedef enum logic [1:0] {
      ACCEPT  = 2'd0,
      CMP_MAX = 2'd1,
      CMP_MIN = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   max_q, max_nxt;
   logic [DATA_W-1:0]   min_q, min_nxt;
   logic [DATA_W-1:0]   cur_q, cur_nxt;
   logic [CNT_W-1:0]    cnt_q, cnt_nxt;
   logic                last_q, last_nxt;
   logic [DATA_W-1:0]   cmp_a_c, cmp_b_c;
`ifdef MINMAX_INDEX_EN
   logic [CNT_W-1:0]    max_idx_q, max_idx_nxt;
   logic [CNT_W-1:0]    min_idx_q, min_idx_nxt;
`endif

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state     <= ACCEPT;
         max_q     <= '0;
         min_q     <= '0;
         cur_q     <= '0;
         cnt_q     <= '0;
         last_q    <= 1'b0;
`ifdef MINMAX_INDEX_EN
         max_idx_q <= '0;
         min_idx_q <= '0;
`endif
      end else begin
         state     <= state_nxt;
         max_q     <= max_nxt;
         min_q     <= min_nxt;
         cur_q     <= cur_nxt;
         cnt_q     <= cnt_nxt;
         last_q    <= last_nxt;
`ifdef MINMAX_INDEX_EN
         max_idx_q <= max_idx_nxt;
         min_idx_q <= min_idx_nxt;
`endif
      end
   end

   // Next-state, datapath update and comparator operand selection
   always_comb begin
      state_nxt   = state;
      max_nxt     = max_q;
      min_nxt     = min_q;
      cur_nxt     = cur_q;
      cnt_nxt     = cnt_q;
      last_nxt    = last_q;
      cmp_a_c     = '0;
      cmp_b_c     = '0;
`ifdef MINMAX_INDEX_EN
      max_idx_nxt = max_idx_q;
      min_idx_nxt = min_idx_q;
`endif
      unique case (state)
         ACCEPT: begin
            if (in_valid) begin
               if (cnt_q == '0) begin
                  // First element seeds both extremes without the comparator
                  max_nxt   = in_data;
                  min_nxt   = in_data;
                  cnt_nxt   = CNT_W'(1);
`ifdef MINMAX_INDEX_EN
                  max_idx_nxt = '0;
                  min_idx_nxt = '0;
`endif
                  state_nxt = in_last ? DONE : ACCEPT;
               end else begin
                  cur_nxt   = in_data;
                  last_nxt  = in_last;
                  state_nxt = CMP_MAX;
               end
            end
         end
         CMP_MAX: begin
            cmp_a_c = cur_q;
            cmp_b_c = max_q;
            // Only a clean one-hot greater-than result updates; ties keep first occurrence
            if (cmp_r == R_GT) begin
               max_nxt = cur_q;
`ifdef MINMAX_INDEX_EN
               max_idx_nxt = cnt_q;
`endif
            end
            state_nxt = CMP_MIN;
         end
         CMP_MIN: begin
            cmp_a_c = cur_q;
            cmp_b_c = min_q;
            if (cmp_r == R_LT) begin
               min_nxt = cur_q;
`ifdef MINMAX_INDEX_EN
               min_idx_nxt = cnt_q;
`endif
            end
            if (cnt_q != CNT_MAX) begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
            state_nxt = last_q ? DONE : ACCEPT;
         end
         DONE: begin
            // Results stay visible; count restarts for the next frame
            cnt_nxt   = '0;
            state_nxt = ACCEPT;
         end
         default: begin
            state_nxt = ACCEPT;
         end
      endcase
   end

   // Handshake and status are decoded from the state register, masked during reset
   assign in_ready = nrst && (state == ACCEPT);
   assign busy     = nrst && ((state == CMP_MAX) || (state == CMP_MIN));
   assign done     = nrst && (state == DONE);

   assign cmp_a    = cmp_a_c;
   assign cmp_b    = cmp_b_c;
   assign max_out  = max_q;
   assign min_out  = min_q;
   assign count    = cnt_q;
`ifdef MINMAX_INDEX_EN
   assign max_idx  = max_idx_q;
   assign min_idx  = min_idx_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_minmax_sequencer.sv
// Scoreboard bench for minmax_sequencer: the driver pushes per-frame expectations
// computed from the element list, and a negedge monitor checks them on each done.
`timescale 1ns/1ps

module tb_minmax_sequencer;

   localparam int unsigned CNT_W   = 5;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             nrst = 1'b0;
   logic             in_valid = 1'b0;
   logic [3:0]       in_data = 4'h0;
   logic             in_last = 1'b0;
   logic             in_ready;
   logic [3:0]       cmp_a, cmp_b;
   logic [2:0]       cmp_r;
   logic [3:0]       max_out, min_out;
   logic [CNT_W-1:0] count;
   logic             busy, done;
`ifdef MINMAX_INDEX_EN
   logic [CNT_W-1:0] max_idx, min_idx;
`endif

   minmax_sequencer #(.CNT_W(CNT_W)) dut (
      .clk      (clk),
      .nrst     (nrst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_last  (in_last),
      .in_ready (in_ready),
      .cmp_a    (cmp_a),
      .cmp_b    (cmp_b),
      .cmp_r    (cmp_r),
      .max_out  (max_out),
      .min_out  (min_out),
      .count    (count),
`ifdef MINMAX_INDEX_EN
      .max_idx  (max_idx),
      .min_idx  (min_idx),
`endif
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // External comparator; in corrupt mode it returns only non-one-hot codes
   bit         corrupt = 1'b0;
   logic [2:0] bad_r   = 3'b000;
   always_comb cmp_r = corrupt ? bad_r : {cmp_a > cmp_b, cmp_a == cmp_b, cmp_a < cmp_b};

   always @(posedge clk) begin
      case ($urandom_range(0, 4))
         0:       bad_r <= 3'b000;
         1:       bad_r <= 3'b011;
         2:       bad_r <= 3'b110;
         3:       bad_r <= 3'b101;
         default: bad_r <= 3'b111;
      endcase
   end

   typedef struct {
      int mx; int mn; int cnt; int mxi; int mni; int lat;
   } exp_t;

   exp_t sb[$];
   int   elems[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   last_mx  = 0;
   int   last_mn  = 0;
   int   cyc      = 0;
   int   start_cyc = 0;
   bit   in_frame  = 1'b0;
   bit   prev_done = 1'b0;
   bit   busy_seen = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: protocol checks every cycle, scoreboard pop on done
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!nrst) begin
         chk("rst_in_ready", int'(in_ready), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_done", int'(done), 0);
         in_frame  = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (busy) begin
            busy_seen = 1'b1;
            chk("ready_while_busy", int'(in_ready), 0);
         end
         if (in_ready || done) begin
            chk("cmp_a_idle", int'(cmp_a), 0);
            chk("cmp_b_idle", int'(cmp_b), 0);
         end
         if (prev_done) begin
            chk("done_one_cycle", int'(done), 0);
            chk("count_cleared", int'(count), 0);
            chk("max_held", int'(max_out), last_mx);
            chk("min_held", int'(min_out), last_mn);
         end
         if (in_valid && in_ready && !in_frame) begin
            in_frame  = 1'b1;
            start_cyc = cyc;
         end
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("max_out", int'(max_out), e.mx);
               chk("min_out", int'(min_out), e.mn);
               chk("count", int'(count), e.cnt);
`ifdef MINMAX_INDEX_EN
               chk("max_idx", int'(max_idx), e.mxi);
               chk("min_idx", int'(min_idx), e.mni);
`endif
               if (e.lat >= 0) chk("latency", cyc - start_cyc, e.lat);
               last_mx = e.mx;
               last_mn = e.mn;
            end
            in_frame = 1'b0;
         end
         prev_done = done;
      end
   end

   // Present one element and hold it until the block takes it
   task automatic push_elem(input logic [3:0] d, input logic l, input bit gapless);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 1, 0);
      @(posedge clk);
      #1;
      if (!gapless || l) begin
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
      if (!gapless) repeat ($urandom_range(0, 2)) @(posedge clk);
      if (!gapless) #1;
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", 1, 0);
         sb.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Reference: extremes and first-occurrence positions straight from the element list
   task automatic send_frame(input bit gapless, input bit bad);
      exp_t e;
      int   n = elems.size();
      e.mx = elems[0]; e.mn = elems[0]; e.mxi = 0; e.mni = 0;
      for (int i = 1; i < n; i++) begin
         if (!bad && elems[i] > e.mx) begin
            e.mx  = elems[i];
            e.mxi = (i > CNT_MAX) ? CNT_MAX : i;
         end
         if (!bad && elems[i] < e.mn) begin
            e.mn  = elems[i];
            e.mni = (i > CNT_MAX) ? CNT_MAX : i;
         end
      end
      e.cnt = (n > CNT_MAX) ? CNT_MAX : n;
      e.lat = gapless ? 1 + 3 * (n - 1) : -1;
      sb.push_back(e);
      corrupt = bad;
      for (int i = 0; i < n; i++) push_elem(4'(elems[i]), (i == n - 1), gapless);
      wait_done();
      corrupt = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      @(negedge clk);
      chk("reset_max", int'(max_out), 0);
      chk("reset_min", int'(min_out), 0);
      chk("reset_count", int'(count), 0);
      chk("reset_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;

      elems = '{5, 2, 12, 12};
      send_frame(1'b1, 1'b0);

      busy_seen = 1'b0;
      elems = '{7};
      send_frame(1'b1, 1'b0);
      chk("busy_single", int'(busy_seen), 0);

      elems = '{3, 3, 3};
      send_frame(1'b1, 1'b0);

      // Non-one-hot comparator codes must leave the seed element in place
      elems = '{4, 9, 1, 4};
      send_frame(1'b1, 1'b1);

      // Reset during CMP_MIN abandons the frame
      push_elem(4'hF, 1'b0, 1'b1);
      push_elem(4'h0, 1'b0, 1'b1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      nrst = 1'b0;
      @(posedge clk);
      #1;
      nrst = 1'b1;
      @(negedge clk);
      chk("abort_max", int'(max_out), 0);
      chk("abort_min", int'(min_out), 0);
      chk("abort_count", int'(count), 0);
      chk("abort_done", int'(done), 0);
      @(posedge clk);
      #1;
      elems = '{9, 1};
      send_frame(1'b1, 1'b0);

      elems.delete();
      for (int i = 0; i < 33; i++) elems.push_back(int'($urandom_range(0, 15)));
      send_frame(1'b1, 1'b0);

      for (int f = 0; f < 12; f++) begin
         elems.delete();
         for (int i = 0; i < int'($urandom_range(1, 10)); i++)
            elems.push_back(int'($urandom_range(0, 15)));
         send_frame(bit'($urandom_range(0, 1)), 1'b0);
      end

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
